vlc_receive_deser: RTL and testbench
====================================

# vlc_receive_deser

Receive-side deserializer for the VLC link: samples the raw photodetector line on the system clock, recovers framed 32-bit words sent MSB-first at the bit rate, and presents each word on a valid/ready port to the downstream write master that stores it in memory. It is the direct consumer of the transmit serializer's bitstream. It adds a start/stop-bit frame, a glitch filter and a single-word output holding register with overflow and framing-error reporting.

## Interface
Parameters:
- CLKS_PER_BIT, 33333: system clocks per line bit (50 MHz / 1.5 kHz); legal range 8..65535.
- CNT_W, 16: width of the bit-period counter.

Ports (one clock; reset is synchronous and active-high):
- iClk  in  1  system clock, 50 MHz.
- iReset  in  1  synchronous, active-high reset.
- iEnable  in  1  receiver enable; low forces IDLE and discards any partial word.
- iData  in  1  raw serial line, asynchronous to iClk.
- iReady  in  1  downstream accepts oData this cycle.
- iClear  in  1  one-cycle pulse; clears oFrame_err and oOverflow.
- oData  out  32  received word.
- oValid  out  1  oData holds an unconsumed word.
- oBusy  out  1  FSM not in IDLE.
- oFrame_err  out  1  sticky; a stop bit was sampled as 1.
- oOverflow  out  1  sticky; a good word was dropped because the holding register was full.
- oWord_cnt  out  32  count of words delivered into the holding register; wraps at 2^32.

## Operation
- Frame on line: idle 0; start bit 1; 32 data bits MSB first; stop bit 0.
- Input conditioning: 2-flop synchronizer, then a 3-sample shift register; filtered line = majority of the 3 samples.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on a rising edge of the filtered line (with iEnable=1), go to START and load the counter with CLKS_PER_BIT/2 - 1.
  - START: when the counter reaches 0, sample the filtered line. If it is 1, go to DATA with bit index 31 and the counter loaded with CLKS_PER_BIT-1. If it is 0, treat it as a false start and return to IDLE with no flag.
  - DATA: at each counter expiry, shift the sample into the LSB of the shift register and reload the counter. After the 32nd sample, go to STOP.
  - STOP: at counter expiry, sample the line.
    - Sample 0: the word is good and is offered to the holding register.
    - Sample 1: set oFrame_err and discard the word.
    - In both cases return to IDLE.
- Holding register:
  - A good word loads it if it is empty, or if iReady=1 in the same cycle (the consume and the load coincide; no overflow).
  - Otherwise the word is dropped and oOverflow is set.
  - oWord_cnt increments only on a load.
- Handshake: a transfer occurs when oValid&iReady. oValid drops the next cycle unless a new word loads in that same cycle.
- iEnable low: FSM goes to IDLE the next cycle and the shift register is discarded. The holding register and flags are kept.
- iClear has priority below a same-cycle set: if a set event and iClear coincide, the flag ends at 1.
- Reset values: oData=0, oValid=0, oBusy=0, oFrame_err=0, oOverflow=0, oWord_cnt=0. The FSM is in IDLE and the synchronizer and filter registers are 0.

## Timing
- Latency from an iData edge to the filtered edge is 4 cycles: 2 synchronizer cycles plus 2 for the majority of 3.
- Sampling points fall at mid-bit relative to the filtered start edge.
- Good word: oValid rises 1 cycle after the STOP-sample cycle. oData and oWord_cnt update in that same cycle.
- The next start edge is accepted in the cycle after the return to IDLE. Back-to-back frames need no idle bits.
- A reset asserted mid-frame takes effect at the next iClk edge and abandons the frame.
- Single-cycle line glitches never reach the FSM.

## Structure
- Shared package vlc_pkg:
  - FSM state enum (IDLE, START, DATA, STOP).
  - Frame constants: START_BIT=1, STOP_BIT=0, WORD_W=32.
  - Default CLKS_PER_BIT. The transmit serializer uses the same constant.
- One natural sub-module: vlc_line_filter. It contains the synchronizer, the majority-of-3 filter and the rising-edge detect, and outputs the filtered line and a rise pulse.
- The FSM, counter, shift register and holding register stay in the top module.

## Test plan
All scenarios use CLKS_PER_BIT=8.
- Single frame 0xA5A5_0F0F, iReady=1 → one oValid cycle with oData=0xA5A5_0F0F and oWord_cnt=1, no flags.
- Two back-to-back frames 0x1, then 0xFFFF_FFFF, with iReady=0 until both have finished → first word held, oOverflow=1, oWord_cnt=1. Then iReady=1 → 0x1 consumed, and oValid falls.
- Frame 0x1234_5678 whose stop bit is 1 → oFrame_err=1, oValid stays 0. An iClear pulse then clears the flag.
- 1-cycle and 3-cycle high pulses on an idle line → no state change, and oBusy returns to 0 within CLKS_PER_BIT/2 + 4 cycles for the 3-cycle pulse (false start).
- iReset or iEnable=0 asserted at bit 16 of a frame, then a clean frame 0xDEAD_BEEF → only 0xDEAD_BEEF is delivered. After reset all outputs are 0.
- Holding register full when a new word completes, with iReady=1 in the same cycle → old word consumed, new word loaded, oOverflow stays 0, oWord_cnt=2.

Source files
------------

// File: rtl/vlc_pkg.sv
// vlc_pkg: shared VLC link types and frame constants
package vlc_pkg;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   localparam logic START_BIT = 1'b1;
   localparam logic STOP_BIT = 1'b0;
   localparam int WORD_W = 32;
   localparam int CLKS_PER_BIT_DEF = 33333;
endpackage

// File: rtl/vlc_line_filter.sv
// vlc_line_filter: synchronizes the raw line, majority-of-3 filters it and flags rising edges
module vlc_line_filter (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic line,
   output logic rise
);
   logic [1:0] sync;
   logic [2:0] win;
   logic line_q;
   always_ff @(posedge clk)
      if (rst) begin
         sync <= '0;
         win <= '0;
         line_q <= 1'b0;
      end else begin
         sync <= {sync[0], raw};
         win <= {win[1:0], sync[1]};
         line_q <= line;
      end
   assign line = (win[0] & win[1]) | (win[0] & win[2]) | (win[1] & win[2]);
   assign rise = line & ~line_q;
endmodule

// File: rtl/vlc_receive_deser.sv
// vlc_receive_deser: recovers framed 32-bit words from the VLC line into a valid/ready holding register
module vlc_receive_deser
   import vlc_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int CNT_W = 16
) (
   input  logic              iClk,
   input  logic              iReset,
   input  logic              iEnable,
   input  logic              iData,
   input  logic              iReady,
   input  logic              iClear,
   output logic [WORD_W-1:0] oData,
   output logic              oValid,
   output logic              oBusy,
   output logic              oFrame_err,
   output logic              oOverflow,
   output logic [31:0]       oWord_cnt
);
   localparam int IDX_W = $clog2(WORD_W);
   localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WORD_W - 1);
   state_t state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] idx;
   logic [WORD_W-1:0] sr;
   logic line, rise, expire, stop_hit, good, ferr_set, load, drop;
   vlc_line_filter u_filter (
      .clk(iClk),
      .rst(iReset),
      .raw(iData),
      .line(line),
      .rise(rise)
   );
   assign expire = cnt == '0;
   assign stop_hit = iEnable && state == STOP && expire;
   assign good = stop_hit && line == STOP_BIT;
   assign ferr_set = stop_hit && line != STOP_BIT;
   // a word may replace the held one when the consumer takes it in the same cycle
   assign load = good && (!oValid || iReady);
   assign drop = good && oValid && !iReady;
   assign oBusy = state != IDLE;
   always_comb begin
      state_nxt = state;
      if (!iEnable) state_nxt = IDLE;
      else
         case (state)
            IDLE:    state_nxt = rise ? START : IDLE;
            START:   state_nxt = expire ? (line == START_BIT ? DATA : IDLE) : START;
            DATA:    state_nxt = (expire && idx == '0) ? STOP : DATA;
            STOP:    state_nxt = expire ? IDLE : STOP;
            default: state_nxt = IDLE;
         endcase
   end
   always_ff @(posedge iClk)
      if (iReset) begin
         state <= IDLE;
         cnt <= '0;
         idx <= '0;
         sr <= '0;
      end else begin
         state <= state_nxt;
         cnt <= (state_nxt != state || expire) ? (state_nxt == START ? HALF : FULL) : cnt - CNT_W'(1);
         idx <= (state == START) ? IDX_TOP : (state == DATA && expire) ? idx - IDX_W'(1) : idx;
         sr <= (state == DATA && expire) ? {sr[WORD_W-2:0], line} : (state == IDLE ? '0 : sr);
      end
   always_ff @(posedge iClk)
      if (iReset) begin
         oData <= '0;
         oValid <= 1'b0;
         oWord_cnt <= '0;
         oFrame_err <= 1'b0;
         oOverflow <= 1'b0;
      end else begin
         oData <= load ? sr : oData;
         oWord_cnt <= load ? oWord_cnt + 32'd1 : oWord_cnt;
         oValid <= load | (oValid & ~iReady);
         oOverflow <= drop | (oOverflow & ~iClear);
         oFrame_err <= ferr_set | (oFrame_err & ~iClear);
      end
endmodule

// File: tb/tb_vlc_receive_deser.sv
// tb_vlc_receive_deser: scenario tasks with a word scoreboard checked at every transfer
module tb_vlc_receive_deser;
   localparam int CPB = 8;
   logic iClk = 1'b0, iReset = 1'b1, iEnable = 1'b0, iData = 1'b0, iReady = 1'b0, iClear = 1'b0;
   logic [31:0] oData, oWord_cnt;
   logic oValid, oBusy, oFrame_err, oOverflow;
   int n_checks = 0, n_fail = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_cnt = 0;
   logic [31:0] sb_exp;

   vlc_receive_deser #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
      .iClk(iClk),
      .iReset(iReset),
      .iEnable(iEnable),
      .iData(iData),
      .iReady(iReady),
      .iClear(iClear),
      .oData(oData),
      .oValid(oValid),
      .oBusy(oBusy),
      .oFrame_err(oFrame_err),
      .oOverflow(oOverflow),
      .oWord_cnt(oWord_cnt)
   );

   always #10 iClk = ~iClk;

   always @(negedge iClk)
      if (oValid && iReady) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_extra: got word %h, expected none", oData);
         end else begin
            sb_exp = exp_q.pop_front();
            if (oData !== sb_exp) begin
               n_fail++;
               $display("FAIL scoreboard_data: got %h, expected %h", oData, sb_exp);
            end
         end
      end

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge iClk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [31:0] w, input logic stop, input bit deliver, input int nbits = 32);
      if (deliver) begin
         exp_q.push_back(w);
         exp_cnt++;
      end
      iData = 1'b1;
      cyc(CPB);
      for (int i = 31; i >= 32 - nbits; i--) begin
         iData = w[i];
         cyc(CPB);
      end
      if (nbits == 32) begin
         iData = stop;
         cyc(CPB);
         iData = 1'b0;
      end
   endtask

   task automatic test_reset();
      iReset = 1'b1;
      iEnable = 1'b1;
      cyc(3);
      @(negedge iClk);
      n_checks++;
      if ({oData, oValid, oBusy, oFrame_err, oOverflow, oWord_cnt} !== 68'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got data=%h v=%b b=%b fe=%b ov=%b cnt=%0d, expected all 0",
                  oData, oValid, oBusy, oFrame_err, oOverflow, oWord_cnt);
      end
      iReset = 1'b0;
      cyc(4);
   endtask

   task automatic test_single();
      int vc = 0;
      iReady = 1'b1;
      send_frame(32'hA5A5_0F0F, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) begin
         @(negedge iClk);
         vc += int'(oValid);
      end
      n_checks++;
      if (vc !== 1) begin
         n_fail++;
         $display("FAIL single_valid_cycles: got %0d, expected 1", vc);
      end
      n_checks++;
      if (oWord_cnt !== exp_cnt) begin
         n_fail++;
         $display("FAIL single_word_cnt: got %0d, expected %0d", oWord_cnt, exp_cnt);
      end
      n_checks++;
      if ({oFrame_err, oOverflow} !== 2'b00) begin
         n_fail++;
         $display("FAIL single_flags: got fe=%b ov=%b, expected 0 0", oFrame_err, oOverflow);
      end
   endtask

   task automatic test_back_to_back();
      iReady = 1'b0;
      cyc(1);
      send_frame(32'h0000_0001, 1'b0, 1'b1);
      send_frame(32'hFFFF_FFFF, 1'b0, 1'b0);
      cyc(3);
      @(negedge iClk);
      n_checks++;
      if ({oValid, oData} !== {1'b1, 32'h0000_0001}) begin
         n_fail++;
         $display("FAIL b2b_held: got v=%b data=%h, expected 1 00000001", oValid, oData);
      end
      n_checks++;
      if (oOverflow !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_overflow: got %b, expected 1", oOverflow);
      end
      n_checks++;
      if (oWord_cnt !== exp_cnt) begin
         n_fail++;
         $display("FAIL b2b_word_cnt: got %0d, expected %0d", oWord_cnt, exp_cnt);
      end
      iReady = 1'b1;
      cyc(1);
      @(negedge iClk);
      n_checks++;
      if (oValid !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_valid_drop: got %b, expected 0", oValid);
      end
      iClear = 1'b1;
      cyc(1);
      iClear = 1'b0;
      @(negedge iClk);
      n_checks++;
      if (oOverflow !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_overflow_clear: got %b, expected 0", oOverflow);
      end
   endtask

   task automatic test_frame_err();
      iReady = 1'b1;
      send_frame(32'h1234_5678, 1'b1, 1'b0);
      cyc(3);
      @(negedge iClk);
      n_checks++;
      if ({oFrame_err, oValid} !== 2'b10) begin
         n_fail++;
         $display("FAIL ferr_set: got fe=%b v=%b, expected 1 0", oFrame_err, oValid);
      end
      n_checks++;
      if (oWord_cnt !== exp_cnt) begin
         n_fail++;
         $display("FAIL ferr_word_cnt: got %0d, expected %0d", oWord_cnt, exp_cnt);
      end
      iClear = 1'b1;
      cyc(1);
      iClear = 1'b0;
      @(negedge iClk);
      n_checks++;
      if (oFrame_err !== 1'b0) begin
         n_fail++;
         $display("FAIL ferr_clear: got %b, expected 0", oFrame_err);
      end
   endtask

   task automatic test_glitch();
      logic seen = 1'b0;
      cyc(4);
      iData = 1'b1;
      cyc(1);
      iData = 1'b0;
      for (int i = 0; i < 12; i++) begin
         @(negedge iClk);
         seen |= oBusy;
      end
      n_checks++;
      if (seen !== 1'b0) begin
         n_fail++;
         $display("FAIL glitch1_busy: got busy seen %b, expected 0", seen);
      end
      cyc(1);
      iData = 1'b1;
      cyc(3);
      iData = 1'b0;
      for (int i = 0; i < CPB / 2 + 4; i++) begin
         @(negedge iClk);
         seen |= oBusy;
      end
      n_checks++;
      if ({seen, oBusy} !== 2'b10) begin
         n_fail++;
         $display("FAIL glitch3_false_start: got seen=%b busy=%b, expected 1 0", seen, oBusy);
      end
      n_checks++;
      if ({oValid, oFrame_err, oOverflow, oWord_cnt} !== {3'b000, exp_cnt}) begin
         n_fail++;
         $display("FAIL glitch_state: got v=%b fe=%b ov=%b cnt=%0d, expected 0 0 0 %0d",
                  oValid, oFrame_err, oOverflow, oWord_cnt, exp_cnt);
      end
   endtask

   task automatic test_coincide();
      iReset = 1'b1;
      cyc(1);
      iReset = 1'b0;
      exp_cnt = 0;
      iReady = 1'b0;
      cyc(4);
      send_frame(32'hAAAA_5555, 1'b0, 1'b1);
      cyc(2);
      @(negedge iClk);
      n_checks++;
      if ({oValid, oData} !== {1'b1, 32'hAAAA_5555}) begin
         n_fail++;
         $display("FAIL coincide_first_held: got v=%b data=%h, expected 1 aaaa5555", oValid, oData);
      end
      send_frame(32'h1357_9BDF, 1'b0, 1'b1);
      iReady = 1'b1;
      cyc(3);
      @(negedge iClk);
      n_checks++;
      if ({oOverflow, oValid} !== 2'b00) begin
         n_fail++;
         $display("FAIL coincide_flags: got ov=%b v=%b, expected 0 0", oOverflow, oValid);
      end
      n_checks++;
      if (oWord_cnt !== 32'd2) begin
         n_fail++;
         $display("FAIL coincide_word_cnt: got %0d, expected 2", oWord_cnt);
      end
   endtask

   task automatic test_abort();
      iReady = 1'b1;
      send_frame(32'hCAFE_BABE, 1'b0, 1'b0, 16);
      iReset = 1'b1;
      iData = 1'b0;
      cyc(1);
      @(negedge iClk);
      n_checks++;
      if ({oData, oValid, oBusy, oFrame_err, oOverflow, oWord_cnt} !== 68'd0) begin
         n_fail++;
         $display("FAIL abort_reset_outputs: got data=%h v=%b b=%b fe=%b ov=%b cnt=%0d, expected all 0",
                  oData, oValid, oBusy, oFrame_err, oOverflow, oWord_cnt);
      end
      exp_cnt = 0;
      iReset = 1'b0;
      cyc(16);
      send_frame(32'hDEAD_BEEF, 1'b0, 1'b1);
      cyc(3);
      @(negedge iClk);
      n_checks++;
      if ({oFrame_err, oWord_cnt} !== {1'b0, exp_cnt}) begin
         n_fail++;
         $display("FAIL abort_reset_recover: got fe=%b cnt=%0d, expected 0 %0d", oFrame_err, oWord_cnt, exp_cnt);
      end
      send_frame(32'hCAFE_BABE, 1'b0, 1'b0, 16);
      iEnable = 1'b0;
      iData = 1'b0;
      cyc(2);
      @(negedge iClk);
      n_checks++;
      if (oBusy !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_enable_idle: got busy %b, expected 0", oBusy);
      end
      iEnable = 1'b1;
      cyc(16);
      send_frame(32'hDEAD_BEEF, 1'b0, 1'b1);
      cyc(3);
      @(negedge iClk);
      n_checks++;
      if ({oFrame_err, oOverflow, oWord_cnt} !== {2'b00, exp_cnt}) begin
         n_fail++;
         $display("FAIL abort_enable_recover: got fe=%b ov=%b cnt=%0d, expected 0 0 %0d",
                  oFrame_err, oOverflow, oWord_cnt, exp_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_frame_err();
      test_glitch();
      test_coincide();
      test_abort();
      cyc(4);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d words pending, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
